// File: rtl/bus_arbiter_n_if.sv
// Request/grant bundle shared between N bus masters and bus_arbiter_n.
// Latency: none, this file only carries wires.
// Backpressure: none; req/lock are levels and the grant is a level.
interface bus_arbiter_n_if #(
  parameter int N_MASTERS = 4,
  parameter int IDW       = $clog2(N_MASTERS)
);
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] lock;
  logic [N_MASTERS-1:0] grnt;
  logic [IDW-1:0]       owner_id;
  logic                 locked;
  logic                 grnt_chg;

  // Requesting side: masters drive req/lock and observe the grant.
  modport master (
    output req,
    output lock,
    input  grnt,
    input  owner_id,
    input  locked,
    input  grnt_chg
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  lock,
    output grnt,
    output owner_id,
    output locked,
    output grnt_chg
  );
endinterface

// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed-priority or round-robin, bus parking, lock, hold-limit preemption.
// Latency: 1 cycle from sampled req to grant; grnt decoded from the registered owner.
// Backpressure: none; a master keeps req high until granted, lock holds the bus against preemption.
module bus_arbiter_n #(
  parameter int N_MASTERS = 4,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 16,
  parameter int IDW       = $clog2(N_MASTERS)
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_arbiter_n_if.slave bus
);

  localparam logic [1:0] ST_PARK   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]           r_state;
  logic [IDW-1:0]       r_owner;
  logic [7:0]           r_hold_cnt;
  logic                 r_grnt_chg;

  logic [1:0]           w_nxt_state;
  logic [IDW-1:0]       w_nxt_owner;
  logic [7:0]           w_nxt_hold;
  logic [N_MASTERS-1:0] w_grnt;
  logic [N_MASTERS-1:0] w_oth;
  logic [IDW:0]         w_pick_all;
  logic [IDW:0]         w_pick_oth;
  logic                 w_own_req;
  logic                 w_own_lock;
  logic                 w_oth_req;
  logic                 w_hold_exp;
  logic                 w_rearb;
  logic                 w_preempt;

  // Returns {found, index}. Round robin searches owner+1 upward with wrap, so the
  // owner itself is the last candidate; fixed priority takes the lowest index.
  function automatic logic [IDW:0] f_pick(input logic [N_MASTERS-1:0] i_cand,
                                          input logic [IDW-1:0]       i_own);
    logic [IDW:0]   v_res;
    logic [IDW:0]   v_sum;
    logic [IDW-1:0] v_idx;
    v_res = '0;
    v_sum = '0;
    v_idx = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N_MASTERS; k++) begin
        v_sum = {1'b0, i_own} + (IDW+1)'(k);
        if (v_sum >= (IDW+1)'(N_MASTERS)) begin
          v_sum = v_sum - (IDW+1)'(N_MASTERS);
        end
        v_idx = v_sum[IDW-1:0];
        if (!v_res[IDW] && i_cand[v_idx]) begin
          v_res = {1'b1, v_idx};
        end
      end
    end else begin
      for (int k = 0; k < N_MASTERS; k++) begin
        v_idx = IDW'(k);
        if (!v_res[IDW] && i_cand[v_idx]) begin
          v_res = {1'b1, v_idx};
        end
      end
    end
    return v_res;
  endfunction

  // One-hot grant decoded from the owner register, so it is never empty or multi-hot.
  always_comb begin
    w_grnt          = '0;
    w_grnt[r_owner] = 1'b1;
  end

  // Next owner/state: re-arbitrate when the owner lets go, lock on request,
  // preempt a non-locked owner once its contended hold reaches MAX_HOLD.
  always_comb begin
    w_oth       = bus.req & ~w_grnt;
    w_own_req   = bus.req[r_owner];
    w_own_lock  = bus.lock[r_owner];
    w_oth_req   = |w_oth;
    w_pick_all  = f_pick(bus.req, r_owner);
    w_pick_oth  = f_pick(w_oth, r_owner);
    w_hold_exp  = (MAX_HOLD != 0) && (r_hold_cnt == 8'(MAX_HOLD));
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_rearb     = 1'b0;
    w_preempt   = 1'b0;

    case (r_state)
      ST_PARK: begin
        w_rearb = 1'b1;
      end
      ST_BUSY: begin
        if (!w_own_req) begin
          w_rearb = 1'b1;
        end else if (w_own_lock) begin
          w_nxt_state = ST_LOCKED;
        end else if (w_hold_exp && w_oth_req) begin
          w_preempt = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!w_own_req) begin
          w_rearb = 1'b1;
        end else if (!w_own_lock) begin
          w_nxt_state = ST_BUSY;
        end
      end
      default: begin
        // Unused encoding: recover by arbitrating as if parked.
        w_rearb = 1'b1;
      end
    endcase

    if (w_rearb) begin
      if (w_pick_all[IDW]) begin
        w_nxt_owner = w_pick_all[IDW-1:0];
        w_nxt_state = bus.lock[w_pick_all[IDW-1:0]] ? ST_LOCKED : ST_BUSY;
      end else begin
        // Nobody wants the bus: park it on the current owner.
        w_nxt_state = ST_PARK;
      end
    end else if (w_preempt) begin
      w_nxt_owner = w_pick_oth[IDW-1:0];
      w_nxt_state = bus.lock[w_pick_oth[IDW-1:0]] ? ST_LOCKED : ST_BUSY;
    end
  end

  // Hold counter only runs while the same owner stays BUSY under contention;
  // re-winning the bus as the same owner does not reset it.
  always_comb begin
    if ((w_nxt_owner != r_owner) || (w_nxt_state != ST_BUSY)) begin
      w_nxt_hold = 8'd0;
    end else if ((r_state == ST_BUSY) && w_oth_req && (r_hold_cnt != 8'hFF)) begin
      w_nxt_hold = r_hold_cnt + 8'd1;
    end else begin
      w_nxt_hold = r_hold_cnt;
    end
  end

  // State registers; reset parks the bus on master 0 and drops any lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_PARK;
      r_owner    <= '0;
      r_hold_cnt <= 8'd0;
      r_grnt_chg <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_owner    <= w_nxt_owner;
      r_hold_cnt <= w_nxt_hold;
      r_grnt_chg <= (w_nxt_owner != r_owner);
    end
  end

  assign bus.grnt     = w_grnt;
  assign bus.owner_id = r_owner;
  assign bus.locked   = (r_state == ST_LOCKED);
  assign bus.grnt_chg = r_grnt_chg;

endmodule
